// File: rtl/com_stream_ctrl_pkg.sv
// rtl/com_stream_ctrl_pkg.sv - phase encodings and default widths for the host stream controller
package com_stream_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_LOAD    = 2'd0,
    ST_COMPUTE = 2'd1,
    ST_DUMP    = 2'd2,
    ST_FINISH  = 2'd3
  } phase_e;

  localparam int DATA_W_DEF = 16;
  localparam int ADDR_W_DEF = 8;

endpackage

// File: rtl/com_stream_ctrl_if.sv
// rtl/com_stream_ctrl_if.sv - shared data memory port between the controller and the memory
interface com_stream_ctrl_if
  import com_stream_ctrl_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
);

  logic              mem_wr_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wr_data;
  logic [DATA_W-1:0] mem_rd_data;

  modport master (
    output mem_wr_en,
    output mem_addr,
    output mem_wr_data,
    input  mem_rd_data
  );

  modport slave (
    input  mem_wr_en,
    input  mem_addr,
    input  mem_wr_data,
    output mem_rd_data
  );

endinterface

// File: rtl/com_dump_seq.sv
// rtl/com_dump_seq.sv - result window read sequencer with start/done framing
module com_dump_seq
  import com_stream_ctrl_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int OUT_BASE  = 0,
  parameter int OUT_COUNT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en_i,
  input  logic [DATA_W-1:0] rd_data_i,
  output logic [ADDR_W-1:0] rd_addr_o,
  output logic [DATA_W-1:0] data_o,
  output logic              start_o,
  output logic              done_o,
  output logic              finished_o
);

  localparam int                CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0]  COUNT = CNT_W'(OUT_COUNT);
  localparam logic [ADDR_W-1:0] BASE  = ADDR_W'(OUT_BASE);

  logic [ADDR_W-1:0] rp_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              v1_q;
  logic              last1_q;
  logic              start_q;
  logic              done_q;
  logic [DATA_W-1:0] data_q;

  logic issue;
  logic issue_last;

  assign issue      = en_i && (cnt_q != COUNT);
  assign issue_last = issue && (cnt_q == (COUNT - CNT_W'(1)));

  // Stage 1 tracks the memory read latency, stage 2 is the registered output word.
  always_ff @(posedge clk) begin
    if (reset) begin
      rp_q    <= BASE;
      cnt_q   <= '0;
      v1_q    <= 1'b0;
      last1_q <= 1'b0;
      start_q <= 1'b0;
      done_q  <= 1'b0;
      data_q  <= '0;
    end else begin
      if (issue) begin
        rp_q  <= rp_q + ADDR_W'(1);
        cnt_q <= cnt_q + CNT_W'(1);
      end
      v1_q    <= issue;
      last1_q <= issue_last;
      start_q <= v1_q;
      done_q  <= done_q | last1_q;
      if (v1_q) begin
        data_q <= rd_data_i;
      end
    end
  end

  assign rd_addr_o  = rp_q;
  assign data_o     = data_q;
  assign start_o    = start_q;
  assign done_o     = done_q;
  assign finished_o = start_q & done_q;

endmodule

// File: rtl/com_stream_ctrl.sv
// rtl/com_stream_ctrl.sv - host load / compute / dump phase controller over the shared data memory
module com_stream_ctrl
  import com_stream_ctrl_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int OUT_BASE  = 0,
  parameter int OUT_COUNT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] com_data_in,
  input  logic              data_write_start,
  input  logic              data_write_done,
  input  logic              cores_done,
  com_stream_ctrl_if.master mem,
  output logic              cores_start,
  output logic [1:0]        state,
  output logic [DATA_W-1:0] com_data_out,
  output logic              output_write_start,
  output logic              output_write_done,
  output logic              load_overflow
);

  localparam logic [ADDR_W-1:0] WP_MAX = '1;

  phase_e            state_q;
  logic [ADDR_W-1:0] wp_q;
  logic              full_q;
  logic              overflow_q;
  logic              cores_start_q;

  logic              host_word;
  logic              wr_en;
  logic [ADDR_W-1:0] rd_addr;
  logic              dump_finished;

  assign host_word = (state_q == ST_LOAD) && data_write_start && !data_write_done;
  assign wr_en     = host_word && !full_q;

  com_dump_seq #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .OUT_BASE (OUT_BASE),
    .OUT_COUNT(OUT_COUNT)
  ) u_dump_seq (
    .clk       (clk),
    .reset     (reset),
    .en_i      (state_q == ST_DUMP),
    .rd_data_i (mem.mem_rd_data),
    .rd_addr_o (rd_addr),
    .data_o    (com_data_out),
    .start_o   (output_write_start),
    .done_o    (output_write_done),
    .finished_o(dump_finished)
  );

  // full_q marks that the last address has been written; wp_q itself stays saturated.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_LOAD;
      wp_q          <= '0;
      full_q        <= 1'b0;
      overflow_q    <= 1'b0;
      cores_start_q <= 1'b0;
    end else begin
      cores_start_q <= 1'b0;
      case (state_q)
        ST_LOAD: begin
          if (data_write_done) begin
            state_q       <= ST_COMPUTE;
            cores_start_q <= 1'b1;
          end else if (data_write_start) begin
            if (full_q) begin
              overflow_q <= 1'b1;
            end else if (wp_q == WP_MAX) begin
              full_q <= 1'b1;
            end else begin
              wp_q <= wp_q + ADDR_W'(1);
            end
          end
        end
        ST_COMPUTE: begin
          if (cores_done) begin
            state_q <= ST_DUMP;
          end
        end
        ST_DUMP: begin
          if (dump_finished) begin
            state_q <= ST_FINISH;
          end
        end
        ST_FINISH: begin
          state_q <= ST_FINISH;
        end
        default: begin
          state_q <= ST_LOAD;
        end
      endcase
    end
  end

  assign mem.mem_wr_en   = wr_en;
  assign mem.mem_addr    = (state_q == ST_DUMP) ? rd_addr : wp_q;
  assign mem.mem_wr_data = wr_en ? com_data_in : '0;

  assign cores_start   = cores_start_q;
  assign state         = state_q;
  assign load_overflow = overflow_q;

endmodule
